// File: rtl/n101_icache_ram_mw.sv
// Multi-way I-cache data RAM with sequenced power-mode controller.
// Define N101_ICACHE_RAM_PARITY_EN to add per-lane even parity storage.
module n101_icache_ram_mw #(
  parameter int AW       = 7,
  parameter int DP       = 128,
  parameter int DW       = 32,
  parameter int MW       = 4,
  parameter int WAYS     = 2,
  parameter int WAKE_CYC = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pwr_ls,
  input  logic               pwr_ds,
  input  logic               pwr_sd,
  output logic [2:0]         pwr_state,
  output logic               ready,
  input  logic               cs,
  input  logic               we,
  input  logic [WAYS-1:0]    way_sel,
  input  logic [AW-1:0]      addr,
  input  logic [MW-1:0]      wem,
  input  logic [DW-1:0]      din,
  output logic [WAYS*DW-1:0] dout,
  output logic               dout_vld,
  output logic [WAYS-1:0]    par_err
);

  localparam int LW = DW / MW;
  localparam logic [3:0] WAKE_LD =
    (WAKE_CYC == 0) ? 4'd0 : 4'(WAKE_CYC - 1);

  typedef enum logic [2:0] {
    ST_ACTIVE = 3'd0,
    ST_LS     = 3'd1,
    ST_DS     = 3'd2,
    ST_SD     = 3'd3,
    ST_WAKE   = 3'd4
  } pwr_t;

  pwr_t       state;
  pwr_t       state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;

  logic in_rng;
  logic acc;
  logic wr;
  logic rd;
  logic clr;

  logic [DW-1:0] mem [WAYS][DP];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_ACTIVE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_ACTIVE: begin
        if (pwr_sd)      state_nxt = ST_SD;
        else if (pwr_ds) state_nxt = ST_DS;
        else if (pwr_ls) state_nxt = ST_LS;
      end
      ST_LS: begin
        if (pwr_sd)       state_nxt = ST_SD;
        else if (pwr_ds)  state_nxt = ST_DS;
        else if (!pwr_ls) state_nxt = ST_ACTIVE;
      end
      ST_DS: begin
        if (pwr_sd) begin
          state_nxt = ST_SD;
        end else if (!pwr_ds) begin
          state_nxt = (WAKE_CYC == 0) ? ST_ACTIVE : ST_WAKE;
          cnt_nxt   = WAKE_LD;
        end
      end
      ST_SD: begin
        if (!pwr_sd) begin
          state_nxt = (WAKE_CYC == 0) ? ST_ACTIVE : ST_WAKE;
          cnt_nxt   = WAKE_LD;
        end
      end
      ST_WAKE: begin
        if (pwr_sd)          state_nxt = ST_SD;
        else if (pwr_ds)     state_nxt = ST_DS;
        else if (cnt == 4'd0) state_nxt = ST_ACTIVE;
        else                 cnt_nxt   = cnt - 4'd1;
      end
      default: begin
        state_nxt = ST_ACTIVE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign pwr_state = state;
  assign ready     = (state == ST_ACTIVE);

  assign in_rng = (32'(addr) < 32'(DP));
  assign acc    = cs & ready;
  assign wr     = acc & we & in_rng & ~rst;
  assign rd     = acc & ~we;
  // Contents are lost on the edge that enters shutdown.
  assign clr    = ~rst & (state != ST_SD) & (state_nxt == ST_SD);

`ifdef N101_ICACHE_RAM_PARITY_EN
  logic [MW-1:0]   par [WAYS][DP];
  logic [WAYS-1:0] rd_err;

  always_comb begin
    rd_err = '0;
    if (in_rng) begin
      for (int k = 0; k < WAYS; k++) begin
        for (int j = 0; j < MW; j++) begin
          rd_err[k] = rd_err[k] |
            ((^mem[k][addr][j*LW +: LW]) ^ par[k][addr][j]);
        end
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < WAYS; k++) begin
        for (int a = 0; a < DP; a++) begin
          mem[k][a] <= '0;
`ifdef N101_ICACHE_RAM_PARITY_EN
          par[k][a] <= '0;
`endif
        end
      end
    end else if (wr) begin
      for (int k = 0; k < WAYS; k++) begin
        for (int j = 0; j < MW; j++) begin
          if (way_sel[k] && wem[j]) begin
            mem[k][addr][j*LW +: LW] <= din[j*LW +: LW];
`ifdef N101_ICACHE_RAM_PARITY_EN
            par[k][addr][j] <= ^din[j*LW +: LW];
`endif
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout     <= '0;
      dout_vld <= 1'b0;
    end else begin
      dout_vld <= rd;
      if (rd) begin
        for (int k = 0; k < WAYS; k++) begin
          dout[k*DW +: DW] <= in_rng ? mem[k][addr] : '0;
        end
      end
    end
  end

`ifdef N101_ICACHE_RAM_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) par_err <= '0;
    else     par_err <= rd ? rd_err : '0;
  end
`else
  assign par_err = '0;
`endif

endmodule

// File: doc/n101_icache_ram_mw.md
Name: n101_icache_ram_mw

Overview:
Multi-way I-cache data RAM for the n101 I-cache. It is the parametrised successor of the single-way icache RAM wrapper.
- Holds WAYS independent byte-maskable arrays behind one shared address port.
- Reads all ways in parallel; writes one or more selected ways.
- Registered 1-cycle read with output hold.
- Adds a sequenced power-mode controller (light sleep / deep sleep / shutdown) with a wake-up counter that back-pressures the I-cache controller through ready.

Parameters:
AW, 7, address width
DP, 128, entries per way (DP <= 2**AW)
DW, 32, data width per way
MW, 4, write-mask width (DW/MW bits per mask bit)
WAYS, 2, number of ways (1..8)
WAKE_CYC, 4, stall cycles after leaving deep sleep or shutdown (0..15)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
pwr_ls  in  1  light-sleep request
pwr_ds  in  1  deep-sleep request (retention)
pwr_sd  in  1  shutdown request (no retention)
pwr_state  out  3  0=ACTIVE 1=LS 2=DS 3=SD 4=WAKE
ready  out  1  access accepted when cs & ready
cs  in  1  access request
we  in  1  1=write, 0=read
way_sel  in  WAYS  write way enables (ignored on read)
addr  in  AW  entry index
wem  in  MW  byte write mask
din  in  DW  write data (same for all selected ways)
dout  out  WAYS*DW  way k at bits [k*DW +: DW]
dout_vld  out  1  one-cycle pulse, dout updated
par_err  out  WAYS  per-way parity error, aligned with dout_vld

Behaviour:
- Reset values: pwr_state=ACTIVE, ready=1, dout=0, dout_vld=0, par_err=0, wake counter=0. RAM contents are not reset.
- ready = (pwr_state==ACTIVE), taken from the registered state only; no combinational path from pwr_* or cs.
- Write (cs&ready&we):
  - Each way with way_sel[k]=1 updates byte lane j where wem[j]=1 at the next edge.
  - way_sel=0 or wem=0 is a no-op.
  - dout and dout_vld are unchanged.
- Read (cs&ready&~we): at the next edge dout loads all ways at addr and dout_vld=1 for that one cycle.
  - dout then holds until the next accepted read, including through sleep states.
- Read the cycle after a write to the same address returns the new data.
- addr >= DP: a write is dropped; a read returns 0 with dout_vld=1.
- Priority for power requests: sd > ds > ls.
- State transitions:
  - ACTIVE: sd -> SD; else ds -> DS; else ls -> LS; else stay.
  - LS: sd -> SD; ds -> DS; ~ls -> ACTIVE (no wake stall).
  - DS: sd -> SD; ~ds -> WAKE with counter loaded WAKE_CYC-1. If WAKE_CYC=0, go straight to ACTIVE.
  - SD: ~sd -> WAKE, same counter rule. On entry to SD all RAM contents are cleared to 0, modelling loss.
  - WAKE: sd -> SD; ds -> DS; counter==0 -> ACTIVE; else decrement. ls in WAKE is ignored until ACTIVE.
- An access accepted in the same cycle a power request rises completes normally; its dout_vld appears one cycle later even though pwr_state has left ACTIVE.
- cs while ready=0 is ignored: no write, no dout_vld.
- rst mid-WAKE or in any sleep state returns to ACTIVE next cycle. RAM is retained except after SD clear.

Optional Feature:
N101_ICACHE_RAM_PARITY_EN
- With the macro defined:
  - Each way stores one even-parity bit per byte lane, written with that lane.
  - On a read, par_err[k]=1 with dout_vld if any lane of way k fails its check.
  - par_err is 0 when dout_vld=0.
  - An SD clear sets parity bits consistent with zero data.
- Without the macro: no parity storage; par_err tied 0.

Test Plan:
1. Reset, write addr=5 way_sel=2'b11 wem=4'hF din=32'hDEADBEEF, read addr=5 -> next cycle dout=64'hDEADBEEF_DEADBEEF, dout_vld=1 for exactly one cycle; dout holds afterwards.
2. Write addr=3 way_sel=2'b01 din=32'h11223344 wem=4'hF, then way_sel=2'b01 din=32'hAABBCCDD wem=4'b0101 -> read addr=3 gives way0=32'h11BB33DD; way1 unchanged.
3. Assert pwr_ds 3 cycles then release, WAKE_CYC=4 -> pwr_state DS,DS,DS,WAKE x4,ACTIVE; ready=0 throughout; cs pulsed during WAKE gives no dout_vld; prior data at addr=5 retained.
4. Write addr=9, then pwr_sd for 2 cycles, release, wait for ready -> read addr=9 returns 0. Raise pwr_ds during WAKE -> state goes to DS.
5. Read accepted in the same cycle pwr_ls rises -> dout_vld next cycle with correct data, pwr_state=LS, ready=0. Drop ls -> ACTIVE next cycle with no stall.
6. With N101_ICACHE_RAM_PARITY_EN, force-flip one stored bit of way1 addr=5 and read -> par_err=2'b10 with dout_vld. Without the macro the same read gives par_err=0.
